// File: rtl/tmr_pkg.sv
// Shared types for the TMR fault manager: replica identifiers, manager FSM states
// and the persistence counter width.
package tmr_pkg;

  typedef enum logic [1:0] {
    REP_A    = 2'd0,
    REP_B    = 2'd1,
    REP_C    = 2'd2,
    REP_NONE = 2'd3
  } replica_id_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REPORT  = 2'd1,
    RESYNC  = 2'd2,
    RECOVER = 2'd3
  } fm_state_t;

  localparam int PERSIST_W = 4;

endpackage

// File: rtl/tmr_fault_manager_if.sv
// Fault report (valid/ready) and resynchronisation (req/ack) channels of the
// TMR fault manager; master is the manager, slave is the consumer.
interface tmr_fault_manager_if #(
  parameter int CNT_W = 8
);
  logic             fault_valid;
  logic             fault_ready;
  logic [1:0]       fault_id;
  logic [CNT_W-1:0] fault_count;
  logic             resync_req;
  logic [1:0]       resync_id;
  logic             resync_ack;

  modport master (
    output fault_valid, fault_id, fault_count, resync_req, resync_id,
    input  fault_ready, resync_ack
  );

  modport slave (
    input  fault_valid, fault_id, fault_count, resync_req, resync_id,
    output fault_ready, resync_ack
  );
endinterface

// File: rtl/tmr_majority_voter.sv
// Combinational bitwise 2-of-3 voter with per-replica mismatch flags and an
// "every replica disagrees" indication.
module tmr_majority_voter #(
  parameter int WIDTH = 13
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             valid,
  output logic [WIDTH-1:0] maj,
  output logic [2:0]       mis,
  output logic             uncorr
);

  // Majority and mismatch decode; mismatches only count on valid samples
  always_comb begin
    maj    = (a & b) | (a & c) | (b & c);
    mis[0] = valid && (a != maj);
    mis[1] = valid && (b != maj);
    mis[2] = valid && (c != maj);
    uncorr = &mis;
  end

endmodule

// File: rtl/tmr_fault_manager.sv
// Registered majority vote of three replicas plus persistence tracking, fault
// reporting and a resync handshake for one faulty replica at a time.
module tmr_fault_manager
  import tmr_pkg::*;
#(
  parameter int WIDTH   = 13,
  parameter int PERSIST = 4,
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rep_a,
  input  logic [WIDTH-1:0] rep_b,
  input  logic [WIDTH-1:0] rep_c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] voted,
  output logic             voted_valid,
  output logic             uncorrectable,
  tmr_fault_manager_if.master fm
);

  localparam logic [PERSIST_W-1:0] PERSIST_V = PERSIST_W'(PERSIST);
  localparam logic [PERSIST_W-1:0] HOLD_LAST = PERSIST_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = {CNT_W{1'b1}};

  logic [WIDTH-1:0]     maj_s;
  logic [2:0]           mis_s;
  logic                 uncorr_s;
  logic [2:0]           hit_s;
  replica_id_t          fault_sel_s;
  logic [CNT_W-1:0]     fcnt_sel_s;

  fm_state_t            state_r, state_nxt_s;
  replica_id_t          id_r, id_nxt_s;
  logic [PERSIST_W-1:0] hold_r, hold_nxt_s;
  logic [PERSIST_W-1:0] pcnt_r [3];
  logic [PERSIST_W-1:0] pcnt_nxt_s [3];
  logic [CNT_W-1:0]     fcnt_r [3];
  logic [CNT_W-1:0]     fcnt_nxt_s [3];

  logic [WIDTH-1:0]     voted_r;
  logic                 voted_valid_r;
  logic                 uncorr_r;
  logic                 fault_valid_r;
  replica_id_t          fault_id_r;
  logic [CNT_W-1:0]     fault_count_r;
  logic                 resync_req_r;
  replica_id_t          resync_id_r;

  tmr_majority_voter #(.WIDTH(WIDTH)) u_voter (
    .a      (rep_a),
    .b      (rep_b),
    .c      (rep_c),
    .valid  (in_valid),
    .maj    (maj_s),
    .mis    (mis_s),
    .uncorr (uncorr_s)
  );

  // Persistent replicas; ties resolve to the lowest index
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit_s[i] = (pcnt_r[i] == PERSIST_V);
    end
    if (hit_s[0]) begin
      fault_sel_s = REP_A;
    end else if (hit_s[1]) begin
      fault_sel_s = REP_B;
    end else if (hit_s[2]) begin
      fault_sel_s = REP_C;
    end else begin
      fault_sel_s = REP_NONE;
    end
  end

  // Next state, persistence counters and lifetime fault counters
  always_comb begin
    state_nxt_s = state_r;
    id_nxt_s    = id_r;
    hold_nxt_s  = hold_r;
    pcnt_nxt_s  = pcnt_r;
    fcnt_nxt_s  = fcnt_r;
    case (state_r)
      IDLE: begin
        if (|hit_s) begin
          id_nxt_s    = fault_sel_s;
          state_nxt_s = REPORT;
          for (int i = 0; i < 3; i++) begin
            if (i == int'(fault_sel_s) && fcnt_r[i] != CNT_MAX) begin
              fcnt_nxt_s[i] = fcnt_r[i] + CNT_W'(1);
            end else begin
              fcnt_nxt_s[i] = fcnt_r[i];
            end
          end
        end else if (in_valid && !uncorr_s) begin
          for (int i = 0; i < 3; i++) begin
            if (mis_s[i]) begin
              pcnt_nxt_s[i] = (pcnt_r[i] >= PERSIST_V) ? PERSIST_V
                                                       : pcnt_r[i] + PERSIST_W'(1);
            end else begin
              pcnt_nxt_s[i] = {PERSIST_W{1'b0}};
            end
          end
        end else begin
          pcnt_nxt_s = pcnt_r;
        end
      end
      REPORT: begin
        if (fault_valid_r && fm.fault_ready) begin
          state_nxt_s = RESYNC;
        end else begin
          state_nxt_s = REPORT;
        end
      end
      RESYNC: begin
        if (resync_req_r && fm.resync_ack) begin
          state_nxt_s = RECOVER;
          hold_nxt_s  = {PERSIST_W{1'b0}};
        end else begin
          state_nxt_s = RESYNC;
        end
      end
      RECOVER: begin
        for (int i = 0; i < 3; i++) begin
          pcnt_nxt_s[i] = {PERSIST_W{1'b0}};
        end
        if (hold_r >= HOLD_LAST) begin
          state_nxt_s = IDLE;
          hold_nxt_s  = {PERSIST_W{1'b0}};
        end else begin
          hold_nxt_s  = hold_r + PERSIST_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        id_nxt_s    = REP_NONE;
      end
    endcase
  end

  // Lifetime count of the replica about to be (or being) reported
  always_comb begin
    case (id_nxt_s)
      REP_A:   fcnt_sel_s = fcnt_nxt_s[0];
      REP_B:   fcnt_sel_s = fcnt_nxt_s[1];
      REP_C:   fcnt_sel_s = fcnt_nxt_s[2];
      default: fcnt_sel_s = {CNT_W{1'b0}};
    endcase
  end

  // State, counters and all outputs registered from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      id_r          <= REP_NONE;
      hold_r        <= {PERSIST_W{1'b0}};
      for (int i = 0; i < 3; i++) begin
        pcnt_r[i] <= {PERSIST_W{1'b0}};
        fcnt_r[i] <= {CNT_W{1'b0}};
      end
      voted_r       <= {WIDTH{1'b0}};
      voted_valid_r <= 1'b0;
      uncorr_r      <= 1'b0;
      fault_valid_r <= 1'b0;
      fault_id_r    <= REP_NONE;
      fault_count_r <= {CNT_W{1'b0}};
      resync_req_r  <= 1'b0;
      resync_id_r   <= REP_NONE;
    end else begin
      state_r       <= state_nxt_s;
      id_r          <= id_nxt_s;
      hold_r        <= hold_nxt_s;
      pcnt_r        <= pcnt_nxt_s;
      fcnt_r        <= fcnt_nxt_s;
      voted_r       <= maj_s;
      voted_valid_r <= in_valid;
      uncorr_r      <= uncorr_s;
      fault_valid_r <= (state_nxt_s == REPORT);
      fault_id_r    <= (state_nxt_s == REPORT) ? id_nxt_s : REP_NONE;
      fault_count_r <= (state_nxt_s == REPORT) ? fcnt_sel_s : {CNT_W{1'b0}};
      resync_req_r  <= (state_nxt_s == RESYNC);
      resync_id_r   <= (state_nxt_s == RESYNC || state_nxt_s == RECOVER) ? id_nxt_s
                                                                          : REP_NONE;
    end
  end

  assign voted          = voted_r;
  assign voted_valid    = voted_valid_r;
  assign uncorrectable  = uncorr_r;
  assign fm.fault_valid = fault_valid_r;
  assign fm.fault_id    = fault_id_r;
  assign fm.fault_count = fault_count_r;
  assign fm.resync_req  = resync_req_r;
  assign fm.resync_id   = resync_id_r;

endmodule
